fir_share_arbiter: RTL
======================

Name: fir_share_arbiter

Overview:
- Time-multiplexes one shared FIR filter instance (16-bit AXI-Stream in, 32-bit out, output has no tready) across NUM_CH independent sample streams.
- Round-robin arbitrates input samples into the FIR and records each accepted sample's channel in a tag FIFO.
- Steers each FIR result back to the originating channel.
- Sits between the per-channel sample sources and the FIR wrapper, in the same aclk domain.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- IN_W, 16, input sample width
- OUT_W, 32, FIR result width
- TAG_DEPTH, 16, maximum samples in flight inside the FIR (power of 2, at least FIR latency + 2)

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- s_tdata  in  NUM_CH*IN_W  per-channel samples; channel k occupies bits [k*IN_W +: IN_W]
- s_tvalid  in  NUM_CH  per-channel valid
- s_tready  out  NUM_CH  per-channel ready
- fir_s_tdata  out  IN_W  sample to the FIR
- fir_s_tvalid  out  1  valid to the FIR
- fir_s_tready  in  1  FIR ready
- fir_m_tdata  in  OUT_W  FIR result
- fir_m_tvalid  in  1  FIR result valid
- m_tdata  out  OUT_W  routed result, shared by all channels
- m_tvalid  out  NUM_CH  one-hot: result belongs to channel k
- m_tchan  out  $clog2(NUM_CH)  channel index of the current result
- in_flight  out  $clog2(TAG_DEPTH)+1  tag FIFO occupancy
- err_underflow  out  1  sticky flag: FIR result arrived with no tag outstanding

Behaviour:
- Interface: one clock, aclk; reset is synchronous and active-high, on port areset.
- Reset values:
  - m_tvalid=0, m_tdata=0, m_tchan=0, in_flight=0, err_underflow=0.
  - Round-robin pointer=0, lock=0, tag FIFO empty.
  - s_tready=0 and fir_s_tvalid=0 during the areset cycle.
- States: IDLE (lock=0) and LOCKED (lock=1, grant register held).
- IDLE:
  - If any s_tvalid and the tag FIFO is not full, grant the first valid channel at or after the pointer, wrapping modulo NUM_CH.
  - Drive fir_s_tvalid=1 and fir_s_tdata=s_tdata[grant] combinationally in the same cycle.
  - If fir_s_tready=1 the handshake completes; stay in IDLE.
  - Otherwise register the grant and go to LOCKED.
- LOCKED:
  - fir_s_tvalid stays 1 with the registered grant. AXI rule: valid is never withdrawn and the channel is never switched.
  - On fir_s_tready=1, handshake completes and the block returns to IDLE.
- s_tready[k] = (k==active grant) & fir_s_tready & fir_s_tvalid. At most one bit is high per cycle.
- On each completed handshake:
  - Push the grant index into the tag FIFO.
  - Set pointer = grant+1, wrapping to 0 after NUM_CH-1.
- Full rule:
  - When in_flight==TAG_DEPTH, no new grant is issued, even if a pop occurs in the same cycle.
  - full is computed from registered occupancy.
  - An already LOCKED transfer cannot hit full, because pushes happen only on handshake.
- Result routing:
  - On fir_m_tvalid=1 with FIFO non-empty, pop the head tag.
  - Next cycle: m_tdata=fir_m_tdata, m_tchan=tag, m_tvalid=one-hot(tag). Latency is exactly 1 cycle.
  - m_tvalid is a single-cycle pulse per result. There is no backpressure, so consumers must accept every pulse.
- Underflow: on fir_m_tvalid=1 with FIFO empty, drop the result, keep m_tvalid=0, and set err_underflow. It clears only on areset.
- Simultaneous push and pop: in_flight is unchanged; both pointers advance.
- Reset mid-operation discards all tags and any LOCKED grant. The parent drives the FIR reset from areset in the same cycle, so no stale results return. A stale result would be flagged as underflow.
- Data widths are passed through unchanged; the block does no arithmetic on samples.

Decomposition:
- Shared package fir_share_pkg holds:
  - constant CH_W = $clog2(NUM_CH)
  - typedef chan_idx_t
  - a round-robin pick function: first set bit of a request vector at or after the pointer, with wrap.
- One natural sub-module: fir_tag_fifo, a synchronous FIFO of width CH_W and depth TAG_DEPTH with push, pop, full, empty and count outputs.

Test Plan:
- Single channel: ch2 sends 0x0001, 0x0002, 0x0003; FIR model has 5-cycle latency and returns x*3. Expect m_tvalid=4'b0100 pulses with data 3, 6, 9, each 1 cycle after fir_m_tvalid; in_flight peaks at 3.
- All 4 channels valid continuously with fir_s_tready=1. Expect grant order 0,1,2,3,0,1…, every s_tready one-hot, and results routed back in the same channel order.
- Backpressure: hold fir_s_tready=0 for 4 cycles while ch1 is granted and ch0/ch3 are also valid. Expect fir_s_tvalid and fir_s_tdata=ch1 stable throughout, then a ch1 handshake, then ch3 granted next.
- Full: FIR model stalls its outputs; push 16 samples. Expect no grant on the 17th cycle while in_flight==16. Release one output; expect a grant the cycle after in_flight drops to 15.
- Underflow: pulse fir_m_tvalid with an empty FIFO carrying 0xDEADBEEF. Expect err_underflow=1 and m_tvalid=0, and the flag stays set until areset.
- Reset mid-stream: assert areset with 5 samples in flight and a LOCKED grant. Next cycle expect in_flight=0, fir_s_tvalid=0, pointer=0; after release, ch0 is granted first.

Source files
------------

// File: rtl/fir_share_pkg.sv
// Shared types and helpers for the FIR time-sharing arbiter.
package fir_share_pkg;

    localparam int DEFAULT_NUM_CH = 4;
    localparam int CH_W           = $clog2(DEFAULT_NUM_CH);

    // Widest request vector the round-robin helper handles (NUM_CH is at most 8).
    localparam int MAX_CH   = 8;
    localparam int MAX_CH_W = 3;

    typedef logic [CH_W-1:0] chan_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // First set bit of req at or after ptr, wrapping modulo n channels.
    function automatic logic [MAX_CH_W-1:0] rr_pick(
        input logic [MAX_CH-1:0]   req,
        input logic [MAX_CH_W-1:0] ptr,
        input int                  n
    );
        logic [MAX_CH_W-1:0] pick;
        logic                found;
        int                  idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && !found && req[idx[MAX_CH_W-1:0]]) begin
                pick  = idx[MAX_CH_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fir_share_arbiter_tag_fifo.sv
// Tag FIFO: remembers the channel of every sample currently inside the FIR.
module fir_tag_fifo
    import fir_share_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array: written on push only.
    // NOTE: the array has no reset; the occupancy counter alone decides which entries are meaningful.
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap on overflow.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_share_arbiter.sv
// Shares one FIR instance between NUM_CH sample streams: round-robin input
// arbitration with AXI-safe locking, tag tracking, and result steering.
module fir_share_arbiter
    import fir_share_pkg::*;
#(
    parameter int NUM_CH    = DEFAULT_NUM_CH,
    parameter int IN_W      = 16,
    parameter int OUT_W     = 32,
    parameter int TAG_DEPTH = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_CH*IN_W-1:0]        s_tdata,
    input  logic [NUM_CH-1:0]             s_tvalid,
    output logic [NUM_CH-1:0]             s_tready,
    output logic [IN_W-1:0]               fir_s_tdata,
    output logic                          fir_s_tvalid,
    input  logic                          fir_s_tready,
    input  logic [OUT_W-1:0]              fir_m_tdata,
    input  logic                          fir_m_tvalid,
    output logic [OUT_W-1:0]              m_tdata,
    output logic [NUM_CH-1:0]             m_tvalid,
    output logic [$clog2(NUM_CH)-1:0]     m_tchan,
    output logic [$clog2(TAG_DEPTH):0]    in_flight,
    output logic                          err_underflow
);

    localparam int CW = $clog2(NUM_CH);

    arb_state_e    state;
    logic [CW-1:0] grant_q;
    logic [CW-1:0] ptr;
    logic [CW-1:0] idle_grant;
    logic [CW-1:0] active;
    logic [CW-1:0] head_tag;
    logic          tag_full;
    logic          tag_empty;
    logic          req_ok;
    logic          handshake;
    logic          pop;

    assign idle_grant   = CW'(rr_pick(MAX_CH'(s_tvalid), MAX_CH_W'(ptr), NUM_CH));
    // Full is judged on registered occupancy, so a same-cycle pop never frees a slot early.
    assign req_ok       = (|s_tvalid) && !tag_full;
    assign active       = (state == LOCKED) ? grant_q : idle_grant;
    assign fir_s_tvalid = !areset && ((state == LOCKED) || req_ok);
    assign fir_s_tdata  = s_tdata[int'(active)*IN_W +: IN_W];
    assign handshake    = fir_s_tvalid && fir_s_tready;
    assign pop          = fir_m_tvalid && !tag_empty;

    // Ready goes back only to the channel whose sample the FIR is taking this cycle.
    // NOTE: defaulting the whole vector first keeps this purely combinational (no latch).
    always_comb begin
        s_tready = '0;
        if (handshake) begin
            s_tready[active] = 1'b1;
        end
    end

    // Arbitration FSM: once valid is shown to the FIR, the grant is frozen until accepted.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ok && !fir_s_tready) begin
                        state   <= LOCKED;
                        grant_q <= idle_grant;
                    end
                end
                LOCKED: begin
                    if (fir_s_tready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (handshake) begin
                ptr <= (active == CW'(NUM_CH - 1)) ? '0 : active + 1'b1;
            end
        end
    end

    fir_tag_fifo #(
        .W     (CW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (handshake),
        .push_data (active),
        .pop       (pop),
        .pop_data  (head_tag),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (in_flight)
    );

    // Result steering: one-cycle registered pulse to the tagged channel; orphan results are flagged.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_tvalid      <= '0;
            m_tdata       <= '0;
            m_tchan       <= '0;
            err_underflow <= 1'b0;
        end else begin
            m_tvalid <= '0;
            if (pop) begin
                m_tvalid <= NUM_CH'(1) << head_tag;
                m_tdata  <= fir_m_tdata;
                m_tchan  <= head_tag;
            end
            if (fir_m_tvalid && tag_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule
